// File: rtl/impix_system_key_debounce.sv
// impix_system_key_debounce: per-channel key debouncer with two-flop sync, edge pulses; option IMPIX_KEY_ACTIVE_LOW_EN inverts key_raw
module impix_system_key_debounce #(
  parameter int WIDTH = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_stable,
  output logic [WIDTH-1:0] key_rise,
  output logic [WIDTH-1:0] key_fall,
  output logic             any_change
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [WIDTH-1:0] raw_in, s1, s2, done;
  logic [CW-1:0] cnt [WIDTH];
`ifdef IMPIX_KEY_ACTIVE_LOW_EN
  assign raw_in = ~key_raw;
`else
  assign raw_in = key_raw;
`endif
  assign any_change = |(key_rise | key_fall);
  // a channel completes when its mismatch has persisted for the full debounce window
  always_comb
    for (int i = 0; i < WIDTH; i++)
      done[i] = (s2[i] != key_stable[i]) && (cnt[i] == LAST);
  // synchronizer, accepted levels, edge pulses
  always_ff @(posedge clk)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      key_stable <= '0;
      key_rise <= '0;
      key_fall <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      key_stable <= key_stable ^ done;
      key_rise <= done & s2;
      key_fall <= done & ~s2;
    end
  // per-channel counters: clear on agreement or acceptance, otherwise count the mismatch
  always_ff @(posedge clk)
    for (int i = 0; i < WIDTH; i++)
      cnt[i] <= (!reset_n || s2[i] == key_stable[i] || done[i]) ? '0 : cnt[i] + 1'b1;
endmodule

// File: doc/impix_system_key_debounce.md
IMPIX_SYSTEM_KEY_DEBOUNCE -- requirements
Module: impix_system_key_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of independent key/switch channels; SHALL match the downstream PIO in_port width.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, consecutive clk cycles a changed level must hold before acceptance; legal range 1..2^20.
REQ-003 Port clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port key_raw  input  WIDTH  asynchronous board key/switch levels.
REQ-006 Port key_stable  output  WIDTH  debounced levels, registered; drives PIO in_port.
REQ-007 Port key_rise  output  WIDTH  one-cycle pulse per bit when key_stable goes 0->1.
REQ-008 Port key_fall  output  WIDTH  one-cycle pulse per bit when key_stable goes 1->0.
REQ-009 Port any_change  output  1  OR-reduction of key_rise|key_fall.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer (s1, s2) before any other logic; no combinational path from key_raw to any output.
REQ-011 Each bit SHALL own a counter of width clog2(DEBOUNCE_CYCLES+1); channels SHALL be fully independent.
REQ-012 Per bit, when s2 equals key_stable, the counter SHALL clear to 0 on the next edge.
REQ-013 Per bit, when s2 differs from key_stable and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 Per bit, when s2 differs from key_stable and counter == DEBOUNCE_CYCLES-1, key_stable SHALL load s2 and the counter SHALL clear on that same edge.
REQ-015 Latency: a key_raw level change held steady SHALL appear on key_stable exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it.
REQ-016 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive s2 samples (glitch/bounce) SHALL clear the counter and SHALL leave key_stable and the pulses unchanged.
REQ-017 key_rise/key_fall SHALL be registered, asserted on the same edge key_stable updates, and deasserted on the next edge; never asserted together for one bit.
REQ-018 Several bits completing on the same edge SHALL each pulse in that cycle; any_change SHALL be high for exactly that cycle.
REQ-019 DEBOUNCE_CYCLES == 1: key_stable SHALL follow s2 with one edge of delay; the counter SHALL never leave 0.
REQ-020 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around path.

Reset
REQ-021 While reset_n is low at a rising edge: s1, s2, counters, key_stable, key_rise, key_fall SHALL be 0; any_change SHALL therefore be 0.
REQ-022 Reset asserted mid-debounce SHALL abort the count with no pulse; after release, a key level of logical 1 SHALL produce one key_rise after DEBOUNCE_CYCLES+2 edges.
REQ-023 Reset release SHALL NOT itself generate any pulse.

Configuration
REQ-024 Macro IMPIX_KEY_ACTIVE_LOW_EN: when defined, each key_raw bit SHALL be inverted before s1, so a pressed (low) key yields key_stable=1 and key_rise on press.
REQ-025 Without IMPIX_KEY_ACTIVE_LOW_EN, key_raw SHALL be used uninverted; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, WIDTH=8, macro undefined unless stated)
REQ-026 key_raw 0x00->0x01 held -> key_stable=0x01 and key_rise=0x01 for one cycle on edge 6 after change; any_change pulses with it.
REQ-027 key_raw bit0 toggled 1,0,1,0 every cycle for 10 cycles, then 0 -> key_stable stays 0x00, no pulses.
REQ-028 bit0 high 3 cycles then low -> no change; bit0 held high 4+ cycles -> rise; then held low -> key_fall=0x01 after 6 edges.
REQ-029 key_raw 0x00->0x81 same cycle -> key_rise=0x81 single cycle; any_change single cycle.
REQ-030 Macro defined, key_raw reset to 0xFF, then bit3 driven low -> key_stable=0x08, key_rise=0x08; reset_n low during count -> no pulse, all outputs 0.
